insmem_arbiter: RTL

Shares the single-port `InsMemory` instruction store among `NUM_CORES` core fetch ports and one program-loader write port. Sits between the per-core fetch units and the memory, and owns the memory's `writeEn`, `address` and `dataIn` pins. Holds cores off until a program has been loaded, then grants one fetch per cycle by round-robin. Stalls all fetches while the loader rewrites memory.

---
 rtl/insmem_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/insmem_arbiter.sv
// Arbitrates the single-port instruction store between NUM_CORES fetch ports and a program loader.
// Define INSMEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module insmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            resetN,
  input  logic [NUM_CORES-1:0]            coreReq,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] coreAddr,
  output logic [NUM_CORES-1:0]            coreGrant,
  output logic [NUM_CORES-1:0]            coreValid,
  output logic [WIDTH-1:0]                coreData,
  input  logic                            ldReq,
  input  logic [ADDR_WIDTH-1:0]           ldAddr,
  input  logic [WIDTH-1:0]                ldData,
  input  logic                            ldDone,
  output logic                            ldGrant,
  output logic                            running,
  output logic                            memWriteEn,
  output logic [ADDR_WIDTH-1:0]           memAddress,
  output logic [WIDTH-1:0]                memDataIn,
  input  logic [WIDTH-1:0]                memDataOut
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic {LOAD, RUN} state_t;

  state_t           state, nextState;
  logic [PTR_W-1:0] rrPtr;
  logic [PTR_W-1:0] sel;
  logic             selVld;
  int               idx;

  // Search order starts at rrPtr and wraps; fixed priority is the same search anchored at 0.
  always_comb begin
    nextState  = state;
    coreGrant  = '0;
    ldGrant    = 1'b0;
    memWriteEn = 1'b0;
    memAddress = '0;
    memDataIn  = ldData;
    sel        = '0;
    selVld     = 1'b0;
    idx        = 0;
    case (state)
      LOAD: begin
        ldGrant    = ldReq;
        memWriteEn = ldReq;
        memAddress = ldAddr;
        if (ldDone) nextState = RUN;
      end
      RUN: begin
        if (ldReq) begin
          nextState = LOAD;
        end else begin
          for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rrPtr) + k) % NUM_CORES;
            if (!selVld && coreReq[idx]) begin
              selVld = 1'b1;
              sel    = PTR_W'(idx);
            end
          end
          if (selVld) begin
            coreGrant[sel] = 1'b1;
            memAddress     = coreAddr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
      end
      default: nextState = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= LOAD;
      running   <= 1'b0;
      coreValid <= '0;
      coreData  <= '0;
    end else begin
      state     <= nextState;
      running   <= (nextState == RUN);
      coreValid <= coreGrant;
      if (selVld) coreData <= memDataOut;
    end
  end

`ifdef INSMEM_ARB_FIXED_PRIO_EN
  assign rrPtr = '0;
`else
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)     rrPtr <= '0;
    else if (selVld) rrPtr <= (sel == PTR_W'(NUM_CORES-1)) ? '0 : sel + 1'b1;
  end
`endif
endmodule
